jtcontra_mdu_arb: RTL and testbench

JTCONTRA_MDU_ARB -- requirements
Module: jtcontra_mdu_arb

---
 rtl/jtcontra_mdu_arb.sv | 146 ++++++++++++++
 tb/tb_jtcontra_mdu_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcontra_mdu_arb.sv
// Two-requester arbiter in front of the shared mul/div unit, with busy-counter stalls.
// Define JTCONTRA_MDU_TIMEOUT_EN to release ownership after 32 idle owner cycles.
module jtcontra_mdu_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_cs_i,
  input  logic       a_wrn_i,
  input  logic [2:0] a_addr_i,
  input  logic [7:0] a_din_i,
  output logic [7:0] a_dout_o,
  output logic       a_wait_o,
  input  logic       b_cs_i,
  input  logic       b_wrn_i,
  input  logic [2:0] b_addr_i,
  input  logic [7:0] b_din_i,
  output logic [7:0] b_dout_o,
  output logic       b_wait_o,
  output logic       u_cs_o,
  output logic       u_wrn_o,
  output logic [2:0] u_addr_o,
  output logic [7:0] u_din_o,
  input  logic [7:0] u_dout_i
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  state_t     state_q, state_d;
  logic       last_b_q;
  logic       rd_pend_q;
  logic [1:0] mul_cnt_q, mul_cnt_d;
  logic [4:0] div_cnt_q, div_cnt_d;
  logic [7:0] a_dout_q, b_dout_q;

  logic       own_cs, own_wrn;
  logic [2:0] own_addr;
  logic [7:0] own_din;
  logic       mul_stall, div_stall;
  logic       acc, wr_acc, rd_start, own_wait;
  logic       rd_release, release_own, timeout;

  // Only the current owner's request is ever visible to the unit.
  always_comb begin
    own_cs   = 1'b0;
    own_wrn  = 1'b1;
    own_addr = 3'd0;
    own_din  = 8'd0;
    case (state_q)
      OWN_A: begin
        own_cs   = a_cs_i;
        own_wrn  = a_wrn_i;
        own_addr = a_addr_i;
        own_din  = a_din_i;
      end
      OWN_B: begin
        own_cs   = b_cs_i;
        own_wrn  = b_wrn_i;
        own_addr = b_addr_i;
        own_din  = b_din_i;
      end
      default: ;
    endcase
  end

  assign mul_stall  = (mul_cnt_q != 2'd0) && own_wrn && (own_addr[2:1] == 2'b00);
  assign div_stall  = (div_cnt_q != 5'd0) && (own_addr >= 3'd2) && (own_addr <= 3'd5);
  assign acc        = own_cs && !rd_pend_q && !mul_stall && !div_stall;
  assign wr_acc     = acc && !own_wrn;
  assign rd_start   = acc && own_wrn;
  assign own_wait   = own_cs && !wr_acc && !rd_pend_q;
  assign rd_release = rd_pend_q && ((own_addr == 3'd1) || (own_addr == 3'd5));
  assign release_own = rd_release || timeout;

  assign a_wait_o = (state_q == OWN_A) ? own_wait : a_cs_i;
  assign b_wait_o = (state_q == OWN_B) ? own_wait : b_cs_i;
  assign u_cs_o   = acc;
  assign u_wrn_o  = !wr_acc;
  assign u_addr_o = own_addr;
  assign u_din_o  = own_din;

  // Read data is forwarded in the completion cycle and held afterwards.
  assign a_dout_o = (rd_pend_q && state_q == OWN_A) ? u_dout_i : a_dout_q;
  assign b_dout_o = (rd_pend_q && state_q == OWN_B) ? u_dout_i : b_dout_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (a_cs_i && (!b_cs_i || last_b_q)) state_d = OWN_A;
        else if (b_cs_i)                     state_d = OWN_B;
      end
      OWN_A: if (release_own) state_d = b_cs_i ? OWN_B : IDLE;
      OWN_B: if (release_own) state_d = a_cs_i ? OWN_A : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mul_cnt_d = (mul_cnt_q != 2'd0) ? mul_cnt_q - 2'd1 : 2'd0;
    div_cnt_d = (div_cnt_q != 5'd0) ? div_cnt_q - 5'd1 : 5'd0;
    if (wr_acc && own_addr[2:1] == 2'b00) mul_cnt_d = 2'd2;
    if (wr_acc && own_addr == 3'd5)       div_cnt_d = 5'd18;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_b_q  <= 1'b1;
      rd_pend_q <= 1'b0;
      mul_cnt_q <= 2'd0;
      div_cnt_q <= 5'd0;
      a_dout_q  <= 8'd0;
      b_dout_q  <= 8'd0;
    end else begin
      state_q   <= state_d;
      if (state_d == OWN_A)      last_b_q <= 1'b0;
      else if (state_d == OWN_B) last_b_q <= 1'b1;
      rd_pend_q <= rd_start;
      mul_cnt_q <= mul_cnt_d;
      div_cnt_q <= div_cnt_d;
      if (rd_pend_q && state_q == OWN_A) a_dout_q <= u_dout_i;
      if (rd_pend_q && state_q == OWN_B) b_dout_q <= u_dout_i;
    end
  end

`ifdef JTCONTRA_MDU_TIMEOUT_EN
  logic [5:0] idle_q, idle_d;

  // Counts owner cycles without a request; the 32nd such cycle gives up ownership.
  always_comb begin
    idle_d  = 6'd0;
    timeout = 1'b0;
    if (state_q != IDLE && !own_cs) begin
      if (idle_q == 6'd31) timeout = 1'b1;
      else                 idle_d  = idle_q + 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= 6'd0;
    else     idle_q <= idle_d;
  end
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_jtcontra_mdu_arb.sv
// Directed bench for jtcontra_mdu_arb with a behavioural unit returning 0xA0+addr on reads.
module tb_jtcontra_mdu_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_cs, a_wrn, b_cs, b_wrn;
  logic [2:0] a_addr, b_addr;
  logic [7:0] a_din, b_din, a_dout, b_dout;
  logic       a_wait, b_wait;
  logic       u_cs, u_wrn;
  logic [2:0] u_addr;
  logic [7:0] u_din, u_dout;

  int vectors = 0;
  int miscompares = 0;
  int n, bad, hi;

  localparam logic [7:0] BASE = 8'hA0;

  jtcontra_mdu_arb dut (
    .clk(clk), .rst(rst),
    .a_cs_i(a_cs), .a_wrn_i(a_wrn), .a_addr_i(a_addr), .a_din_i(a_din),
    .a_dout_o(a_dout), .a_wait_o(a_wait),
    .b_cs_i(b_cs), .b_wrn_i(b_wrn), .b_addr_i(b_addr), .b_din_i(b_din),
    .b_dout_o(b_dout), .b_wait_o(b_wait),
    .u_cs_o(u_cs), .u_wrn_o(u_wrn), .u_addr_o(u_addr), .u_din_o(u_din),
    .u_dout_i(u_dout)
  );

  always #5 clk = ~clk;

  // Unit model: registered read data, one cycle after the address.
  always @(posedge clk) if (u_cs && u_wrn) u_dout <= BASE + {5'd0, u_addr};

  task automatic chkb(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drv_a(input logic cs, input logic wrn, input logic [2:0] addr, input logic [7:0] din);
    a_cs = cs; a_wrn = wrn; a_addr = addr; a_din = din;
  endtask

  task automatic drv_b(input logic cs, input logic wrn, input logic [2:0] addr, input logic [7:0] din);
    b_cs = cs; b_wrn = wrn; b_addr = addr; b_din = din;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    drv_a(1'b0, 1'b1, 3'd0, 8'd0);
    drv_b(1'b0, 1'b1, 3'd0, 8'd0);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    u_dout = 8'd0;
    drv_a(1'b0, 1'b1, 3'd0, 8'd0);
    drv_b(1'b0, 1'b1, 3'd0, 8'd0);
    repeat (2) @(posedge clk);
    #1;
    chkb("rst_ucs", u_cs, 1'b0);
    chkb("rst_uwrn", u_wrn, 1'b1);
    chk8("rst_uaddr", {5'd0, u_addr}, 8'd0);
    chk8("rst_udin", u_din, 8'd0);
    chk8("rst_adout", a_dout, 8'd0);
    chk8("rst_bdout", b_dout, 8'd0);
    chkb("rst_await", a_wait, 1'b0);
    chkb("rst_bwait", b_wait, 1'b0);
    rst = 1'b0;

    // Multiply, single requester
    drv_a(1'b1, 1'b0, 3'd0, 8'h12); #1;
    chkb("grant_await", a_wait, 1'b1);
    chkb("grant_ucs", u_cs, 1'b0);
    nxt();
    chkb("wr0_ucs", u_cs, 1'b1);
    chkb("wr0_uwrn", u_wrn, 1'b0);
    chk8("wr0_uaddr", {5'd0, u_addr}, 8'd0);
    chk8("wr0_udin", u_din, 8'h12);
    chkb("wr0_await", a_wait, 1'b0);
    nxt();
    drv_a(1'b1, 1'b0, 3'd1, 8'h34); #1;
    chk8("wr1_uaddr", {5'd0, u_addr}, 8'd1);
    chk8("wr1_udin", u_din, 8'h34);
    chkb("wr1_await", a_wait, 1'b0);
    nxt();
    drv_a(1'b1, 1'b1, 3'd0, 8'd0); #1;
    chkb("mul_stall1_await", a_wait, 1'b1);
    chkb("mul_stall1_ucs", u_cs, 1'b0);
    nxt();
    chkb("mul_stall2_await", a_wait, 1'b1);
    chkb("mul_stall2_ucs", u_cs, 1'b0);
    nxt();
    chkb("rd0_c1_ucs", u_cs, 1'b1);
    chkb("rd0_c1_uwrn", u_wrn, 1'b1);
    chkb("rd0_c1_await", a_wait, 1'b1);
    nxt();
    chkb("rd0_c2_await", a_wait, 1'b0);
    chk8("rd0_adout", a_dout, 8'hA0);
    nxt();
    drv_a(1'b1, 1'b1, 3'd1, 8'd0); #1;
    chkb("rd1_c1_ucs", u_cs, 1'b1);
    chk8("rd1_c1_uaddr", {5'd0, u_addr}, 8'd1);
    nxt();
    chkb("rd1_c2_await", a_wait, 1'b0);
    chk8("rd1_adout", a_dout, 8'hA1);
    nxt();
    // Released to IDLE: b must see a grant cycle first
    drv_a(1'b0, 1'b1, 3'd0, 8'd0);
    drv_b(1'b1, 1'b1, 3'd6, 8'd0); #1;
    chkb("b_grant_bwait", b_wait, 1'b1);
    chkb("b_grant_ucs", u_cs, 1'b0);
    chk8("a_dout_hold", a_dout, 8'hA1);
    nxt();
    chkb("b_rd6_ucs", u_cs, 1'b1);
    chk8("b_rd6_uaddr", {5'd0, u_addr}, 8'd6);
    chkb("b_rd6_bwait", b_wait, 1'b1);
    nxt();
    chkb("b_rd6_c2_bwait", b_wait, 1'b0);
    chk8("b_rd6_bdout", b_dout, 8'hA6);
    chk8("a_dout_hold2", a_dout, 8'hA1);
    nxt();
    drv_b(1'b1, 1'b1, 3'd1, 8'd0);
    nxt();
    nxt();
    drv_b(1'b0, 1'b1, 3'd0, 8'd0);

    // Divide stall
    drv_a(1'b1, 1'b0, 3'd2, 8'h07); nxt();
    nxt();
    drv_a(1'b1, 1'b0, 3'd3, 8'h00); nxt();
    drv_a(1'b1, 1'b0, 3'd4, 8'h64); nxt();
    drv_a(1'b1, 1'b0, 3'd5, 8'h00); #1;
    chkb("wr5_ucs", u_cs, 1'b1);
    chkb("wr5_await", a_wait, 1'b0);
    nxt();
    drv_a(1'b1, 1'b1, 3'd4, 8'd0); #1;
    n = 0; bad = 0; hi = 0;
    while (a_wait === 1'b1 && n < 40) begin
      if (u_cs) hi++;
      if (n < 18 && u_cs) bad++;
      n++;
      nxt();
    end
    chki("div_wait_cycles", n, 19);
    chki("div_stall_ucs", bad, 0);
    chki("div_read_ucs", hi, 1);
    chk8("div_rd4_adout", a_dout, 8'hA4);
    nxt();
    drv_a(1'b1, 1'b1, 3'd5, 8'd0); #1;
    chkb("rd5_ucs", u_cs, 1'b1);
    nxt();
    chk8("rd5_adout", a_dout, 8'hA5);
    nxt();
    // Tie with a as last owner goes to b
    drv_a(1'b1, 1'b1, 3'd6, 8'd0);
    drv_b(1'b1, 1'b1, 3'd7, 8'd0); #1;
    nxt();
    chk8("tie_last_a_uaddr", {5'd0, u_addr}, 8'd7);
    chkb("tie_last_a_await", a_wait, 1'b1);

    // Contention after reset
    do_reset();
    drv_a(1'b1, 1'b1, 3'd5, 8'd0);
    drv_b(1'b1, 1'b1, 3'd7, 8'd0); #1;
    chkb("cont_grant_await", a_wait, 1'b1);
    chkb("cont_grant_bwait", b_wait, 1'b1);
    nxt();
    chkb("cont_a_ucs", u_cs, 1'b1);
    chk8("cont_a_uaddr", {5'd0, u_addr}, 8'd5);
    chkb("cont_a_bwait", b_wait, 1'b1);
    nxt();
    chkb("cont_a_done_await", a_wait, 1'b0);
    chkb("cont_a_done_bwait", b_wait, 1'b1);
    chk8("cont_a_adout", a_dout, 8'hA5);
    nxt();
    drv_a(1'b0, 1'b1, 3'd0, 8'd0); #1;
    chkb("handoff_ucs", u_cs, 1'b1);
    chk8("handoff_uaddr", {5'd0, u_addr}, 8'd7);
    nxt();
    chkb("handoff_bwait", b_wait, 1'b0);
    chk8("handoff_bdout", b_dout, 8'hA7);
    nxt();
    drv_b(1'b1, 1'b1, 3'd1, 8'd0);
    nxt();
    nxt();
    drv_a(1'b1, 1'b1, 3'd6, 8'd0);
    drv_b(1'b1, 1'b1, 3'd7, 8'd0); #1;
    nxt();
    chk8("tie_last_b_uaddr", {5'd0, u_addr}, 8'd6);
    chkb("tie_last_b_bwait", b_wait, 1'b1);

    // Reset mid-divide
    do_reset();
    drv_a(1'b1, 1'b0, 3'd5, 8'h01);
    nxt();
    nxt();
    drv_a(1'b0, 1'b1, 3'd0, 8'd0);
    repeat (4) nxt();
    rst = 1'b1; #1;
    chkb("midrst_ucs", u_cs, 1'b0);
    chkb("midrst_uwrn", u_wrn, 1'b1);
    chk8("midrst_uaddr", {5'd0, u_addr}, 8'd0);
    chk8("midrst_adout", a_dout, 8'd0);
    chkb("midrst_await", a_wait, 1'b0);
    nxt();
    rst = 1'b0;
    drv_a(1'b1, 1'b1, 3'd4, 8'd0); #1;
    nxt();
    chkb("postrst_rd4_ucs", u_cs, 1'b1);
    nxt();
    chkb("postrst_rd4_await", a_wait, 1'b0);
    chk8("postrst_rd4_adout", a_dout, 8'hA4);

    // Idle owner with b waiting
    do_reset();
    drv_a(1'b1, 1'b0, 3'd0, 8'h55);
    nxt();
    nxt();
    drv_a(1'b0, 1'b1, 3'd0, 8'd0);
    drv_b(1'b1, 1'b1, 3'd6, 8'd0); #1;
    n = 0; bad = 0;
    while (u_cs !== 1'b1 && n < 40) begin
      if (b_wait !== 1'b1) bad++;
      n++;
      nxt();
    end
    chki("idle_bwait_low", bad, 0);
`ifdef JTCONTRA_MDU_TIMEOUT_EN
    chki("timeout_cycles", n, 32);
    chk8("timeout_b_uaddr", {5'd0, u_addr}, 8'd6);
`else
    chki("no_timeout_cycles", n, 40);
    chkb("no_timeout_bwait", b_wait, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
